// File: rtl/stable_check_pkg.sv
// Shared types and constants for the stable-check scheduler.
// Latency: none (types only).
// Backpressure: n/a.
package stable_check_pkg;

    // Largest supported channel count and the field widths sized for it.
    localparam int NCH_MAX  = 16;
    localparam int CH_W_MAX = 4;
    localparam int TS_W_MAX = 32;

    // Fail counters stop here instead of wrapping.
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    // One reported verdict. Fields are sized for the largest build.
    // Narrower instances zero-extend into them.
    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic                pass;
        logic [TS_W_MAX-1:0] ts;
    } evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Scan the request vector from ptr upwards and wrap; the first hit wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/stable_check_sched.sv
// Per-channel $stable checker bank; verdicts are serialised onto one event port.
// Latency: a verdict at edge E is presented on evt_* at edge E+1 at the earliest.
// Backpressure: evt_* holds while !evt_ready; a full slot drops new verdicts and sets ovf.
module stable_check_sched
    import stable_check_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int W           = 8,
    parameter int TSW         = 16,
    parameter bit REPORT_PASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH*W-1:0]       sig,
    input  logic                   clr,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [$clog2(NCH)-1:0] evt_ch,
    output logic                   evt_pass,
    output logic [TSW-1:0]         evt_ts,
    output logic [NCH*16-1:0]      fail_cnt,
    output logic [NCH-1:0]         ovf
);

    localparam int CHW = $clog2(NCH);

    logic [TSW-1:0]     ts_q;
    logic [CHW-1:0]     rr_q;
    logic [NCH-1:0]     slot_vld;
    logic [NCH-1:0]     slot_pass;
    logic [NCH*TSW-1:0] slot_ts;
    logic [NCH-1:0]     gnt;
    logic [CHW-1:0]     gnt_idx;
    logic               gnt_any;
    logic               load_out;
    logic               take;
    logic [NCH-1:0]     freed;
    logic               sel_pass;
    logic [TSW-1:0]     sel_ts;
    evt_t               out_q;
    logic               out_vld_q;
    logic               unused_hi;

    // The output register can accept a new event when it is empty or is draining this edge.
    assign load_out = !out_vld_q || evt_ready;
    assign take     = load_out && gnt_any;
    assign freed    = take ? gnt : '0;

    rr_arbiter #(.N(NCH)) u_arb (
        .req (slot_vld),
        .ptr (rr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Free-running timestamp of each sampling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0]   prev_q;
        logic [W-1:0]   cur;
        logic           same;
        logic           fail;
        logic           report;
        logic           vld_q;
        logic           pass_q;
        logic [TSW-1:0] sts_q;
        logic [15:0]    cnt_q;
        logic           ovf_q;

        assign cur    = sig[i*W +: W];
        assign same   = (cur == prev_q);
        assign fail   = en[i] && !same;
        assign report = en[i] && (!same || REPORT_PASS);

        // One-cycle history of the checked signal, captured regardless of en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) prev_q <= '0;
            else     prev_q <= cur;
        end

        // Single-entry verdict slot; a slot granted this edge may reload at once.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                pass_q <= 1'b0;
                sts_q  <= '0;
            end else if (report && (!vld_q || freed[i])) begin
                vld_q  <= 1'b1;
                pass_q <= same;
                sts_q  <= ts_q;
            end else if (freed[i]) begin
                vld_q  <= 1'b0;
            end
        end

        // Saturating fail counter; a fail on the clr edge leaves the count at 1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                         cnt_q <= '0;
            else if (clr)                    cnt_q <= fail ? 16'd1 : 16'd0;
            else if (fail && cnt_q != CNT_SAT) cnt_q <= cnt_q + 16'd1;
        end

        // Sticky drop flag; a drop on the clr edge keeps the flag set.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                               ovf_q <= 1'b0;
            else if (report && vld_q && !freed[i]) ovf_q <= 1'b1;
            else if (clr)                          ovf_q <= 1'b0;
        end

        assign slot_vld[i]              = vld_q;
        assign slot_pass[i]             = pass_q;
        assign slot_ts[i*TSW +: TSW]    = sts_q;
        assign fail_cnt[i*16 +: 16]     = cnt_q;
        assign ovf[i]                   = ovf_q;
    end

    assign sel_pass = slot_pass[gnt_idx];
    assign sel_ts   = slot_ts[gnt_idx*TSW +: TSW];

    // Output register: take the granted slot whenever the consumer side has room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (load_out) begin
            out_vld_q <= gnt_any;
            if (gnt_any) begin
                out_q.ch   <= CH_W_MAX'(gnt_idx);
                out_q.pass <= sel_pass;
                out_q.ts   <= TS_W_MAX'(sel_ts);
            end
        end
    end

    // Round-robin pointer moves past the channel that was just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rr_q <= '0;
        else if (take) rr_q <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign evt_valid = out_vld_q;
    assign evt_ch    = out_q.ch[CHW-1:0];
    assign evt_pass  = out_q.pass;
    assign evt_ts    = out_q.ts[TSW-1:0];

    // Upper struct bits beyond this instance's widths are always zero.
    assign unused_hi = ^{out_q.ch, out_q.ts};

endmodule

// File: tb/tb_stable_check_sched.sv
// Directed bench for stable_check_sched: one reporting-all instance and one fails-only instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: evt_ready driven per step to exercise hold and drop paths.
module tb_stable_check_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  en_a, en_b;
    logic [31:0] sig_a, sig_b;
    logic        clr_a, clr_b;
    logic        ready_a, ready_b;
    logic        evt_valid_a, evt_valid_b;
    logic [1:0]  evt_ch_a, evt_ch_b;
    logic        evt_pass_a, evt_pass_b;
    logic [15:0] evt_ts_a, evt_ts_b;
    logic [63:0] fail_cnt_a, fail_cnt_b;
    logic [3:0]  ovf_a, ovf_b;

    int tests;
    int fails;
    int cyc;
    int ts_mark;

    // T1 stimulus and expected event stream for channel 0.
    bit t1_en  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit t1_sig [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit t1_v   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit t1_p   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int t1_ts  [8] = '{0, 0, 2, 3, 0, 5, 6, 0};

    stable_check_sched #(.NCH(4), .W(8), .TSW(16), .REPORT_PASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .sig(sig_a), .clr(clr_a),
        .evt_valid(evt_valid_a), .evt_ready(ready_a), .evt_ch(evt_ch_a),
        .evt_pass(evt_pass_a), .evt_ts(evt_ts_a), .fail_cnt(fail_cnt_a), .ovf(ovf_a)
    );

    stable_check_sched #(.NCH(4), .W(8), .TSW(16), .REPORT_PASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .sig(sig_b), .clr(clr_b),
        .evt_valid(evt_valid_b), .evt_ready(ready_b), .evt_ch(evt_ch_b),
        .evt_pass(evt_pass_b), .evt_ts(evt_ts_b), .fail_cnt(fail_cnt_b), .ovf(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sampling edge; cyc tracks the timestamp the next edge will carry.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en_a  = '0;
        sig_a = '0;
        en_b  = '0;
        sig_b = '0;
        clr_a = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        ts_mark = 0;
        rst     = 1'b1;
        en_a    = '0;
        sig_a   = '0;
        clr_a   = 1'b0;
        ready_a = 1'b1;
        en_b    = '0;
        sig_b   = '0;
        clr_b   = 1'b0;
        ready_b = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(evt_valid_a), 32'd0);
        check("rst_ch", 32'(evt_ch_a), 32'd0);
        check("rst_pass", 32'(evt_pass_a), 32'd0);
        check("rst_ts", 32'(evt_ts_a), 32'd0);
        check("rst_cnt_lo", fail_cnt_a[31:0], 32'd0);
        check("rst_cnt_hi", fail_cnt_a[63:32], 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_tsq", 32'(dut_a.ts_q), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // T1: single channel stream, ready held high
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                en_a  = {3'b000, t1_en[k]};
                sig_a = {31'd0, t1_sig[k]};
            end else begin
                en_a  = '0;
            end
            tick();
            check("t1_valid", 32'(evt_valid_a), 32'(t1_v[k]));
            if (t1_v[k]) begin
                check("t1_pass", 32'(evt_pass_a), 32'(t1_p[k]));
                check("t1_ts", 32'(evt_ts_a), 32'(t1_ts[k]));
                check("t1_ch", 32'(evt_ch_a), 32'd0);
            end
        end
        check("t1_cnt0", 32'(fail_cnt_a[15:0]), 32'd3);

        // T2: all channels fail on the first edge after reset (compare against 0)
        do_reset();
        en_a  = 4'hF;
        sig_a = 32'hFFFF_FFFF;
        tick();
        en_a = '0;
        check("t2_lat", 32'(evt_valid_a), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_valid", 32'(evt_valid_a), 32'd1);
            check("t2_ch", 32'(evt_ch_a), 32'(k));
            check("t2_pass", 32'(evt_pass_a), 32'd0);
            check("t2_ts", 32'(evt_ts_a), 32'd0);
        end
        tick();
        check("t2_drain", 32'(evt_valid_a), 32'd0);
        check("t2_cnt_lo", fail_cnt_a[31:0], 32'h0001_0001);
        check("t2_cnt_hi", fail_cnt_a[63:32], 32'h0001_0001);

        // T3: clr, then backpressure while channel 1 fails every edge
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t3_clr_lo", fail_cnt_a[31:0], 32'd0);
        check("t3_clr_hi", fail_cnt_a[63:32], 32'd0);
        ready_a = 1'b0;
        en_a    = 4'b0010;
        ts_mark = cyc;
        sig_a[15:8] = 8'h00;
        tick();
        check("t3_lat", 32'(evt_valid_a), 32'd0);
        sig_a[15:8] = 8'hFF;
        tick();
        check("t3_valid", 32'(evt_valid_a), 32'd1);
        check("t3_ch", 32'(evt_ch_a), 32'd1);
        check("t3_ts", 32'(evt_ts_a), 32'(ts_mark));
        sig_a[15:8] = 8'h00;
        tick();
        check("t3_hold_valid", 32'(evt_valid_a), 32'd1);
        check("t3_hold_ch", 32'(evt_ch_a), 32'd1);
        check("t3_hold_pass", 32'(evt_pass_a), 32'd0);
        check("t3_hold_ts", 32'(evt_ts_a), 32'(ts_mark));
        check("t3_ovf", 32'(ovf_a), 32'b0010);
        check("t3_cnt1", 32'(fail_cnt_a[31:16]), 32'd3);
        en_a    = '0;
        ready_a = 1'b1;
        tick();
        check("t3_next_valid", 32'(evt_valid_a), 32'd1);
        check("t3_next_ts", 32'(evt_ts_a), 32'(ts_mark + 1));
        tick();
        check("t3_drain", 32'(evt_valid_a), 32'd0);

        // T4: fails-only instance sees a constant signal, then one change
        sig_b = 32'h5A5A_5A5A;
        tick();
        en_b = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_no_evt", 32'(evt_valid_b), 32'd0);
        end
        check("t4_cnt_lo", fail_cnt_b[31:0], 32'd0);
        check("t4_cnt_hi", fail_cnt_b[63:32], 32'd0);
        ts_mark = cyc;
        sig_b[7:0] = 8'h00;
        tick();
        en_b = '0;
        tick();
        check("t4_fail_valid", 32'(evt_valid_b), 32'd1);
        check("t4_fail_pass", 32'(evt_pass_b), 32'd0);
        check("t4_fail_ts", 32'(evt_ts_b), 32'(ts_mark));
        check("t4_fail_cnt", 32'(fail_cnt_b[15:0]), 32'd1);

        // T5: drive channel 2 to saturation with back-to-back fails
        en_a = 4'b0100;
        for (int k = 0; k < 65534; k++) begin
            sig_a[23:16] = ~sig_a[23:16];
            tick();
        end
        check("t5_fffe", 32'(fail_cnt_a[47:32]), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            sig_a[23:16] = ~sig_a[23:16];
            tick();
            check("t5_sat", 32'(fail_cnt_a[47:32]), 32'h0000_FFFF);
        end
        check("t5_b2b_valid", 32'(evt_valid_a), 32'd1);
        check("t5_b2b_ch", 32'(evt_ch_a), 32'd2);
        check("t5_b2b_ts", 32'(evt_ts_a), 32'(16'(cyc - 2)));
        check("t5_ovf_sticky", 32'(ovf_a), 32'b0010);
        clr_a = 1'b1;
        sig_a[23:16] = ~sig_a[23:16];
        tick();
        clr_a = 1'b0;
        en_a  = '0;
        check("t5_clr_fail", 32'(fail_cnt_a[47:32]), 32'd1);
        check("t5_clr_ch1", 32'(fail_cnt_a[31:16]), 32'd0);
        check("t5_clr_ovf", 32'(ovf_a), 32'd0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("t5_clr", 32'(fail_cnt_a[47:32]), 32'd0);
        repeat (3) tick();

        // T6: asynchronous reset while an event is held
        ready_a = 1'b0;
        en_a    = 4'b1000;
        sig_a[31:24] = ~sig_a[31:24];
        tick();
        en_a = '0;
        tick();
        check("t6_pre_valid", 32'(evt_valid_a), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(evt_valid_a), 32'd0);
        check("t6_cnt_lo", fail_cnt_a[31:0], 32'd0);
        check("t6_cnt_hi", fail_cnt_a[63:32], 32'd0);
        check("t6_ovf", 32'(ovf_a), 32'd0);
        check("t6_tsq", 32'(dut_a.ts_q), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cyc     = 0;
        ready_a = 1'b1;
        en_a    = 4'b0001;
        sig_a   = 32'h0000_00FF;
        tick();
        en_a = '0;
        tick();
        check("t6_post_valid", 32'(evt_valid_a), 32'd1);
        check("t6_post_ch", 32'(evt_ch_a), 32'd0);
        check("t6_post_ts", 32'(evt_ts_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
